// File: rtl/risc_spm.sv
// risc_spm: 8-bit stored-program CPU (multi-cycle controller, R0-R3, 256x8 unified memory).
// Optional: define RISC_SPM_ILLEGAL_HALT_EN to halt on undefined opcodes instead of NOP.

module risc_spm_ram #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MEM_SIZE  = 256
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  output logic [WORD_SIZE-1:0] rdata_o
);
  localparam int unsigned AddrW = $clog2(MEM_SIZE);

  logic [WORD_SIZE-1:0] memory [0:MEM_SIZE-1];

  assign rdata_o = memory[addr_i[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i[AddrW-1:0]] <= wdata_i;
    end
  end
endmodule

module risc_spm #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MEM_SIZE  = 256
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StFet1 = 4'd1,
    StFet2 = 4'd2,
    StDec  = 4'd3,
    StEx1  = 4'd4,
    StRd1  = 4'd5,
    StRd2  = 4'd6,
    StWr1  = 4'd7,
    StWr2  = 4'd8,
    StBr1  = 4'd9,
    StBr2  = 4'd10,
    StHalt = 4'd11
  } state_e;

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpNot  = 4'b0100;
  localparam logic [3:0] OpRd   = 4'b0101;
  localparam logic [3:0] OpWr   = 4'b0110;
  localparam logic [3:0] OpBr   = 4'b0111;
  localparam logic [3:0] OpBrz  = 4'b1000;
  localparam logic [3:0] OpHalt = 4'b1111;

  localparam logic [WORD_SIZE-1:0] One = 1;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] r_q [4];
  logic [WORD_SIZE-1:0] r_d [4];
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] ar_q, ar_d;
  logic [WORD_SIZE-1:0] y_q, y_d;
  logic                 z_q, z_d;

  logic [WORD_SIZE-1:0] mem_rdata;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] alu_res;
  logic [3:0]           opcode;
  logic [1:0]           src;
  logic [1:0]           dest;

  assign opcode    = ir_q[7:4];
  assign src       = ir_q[3:2];
  assign dest      = ir_q[1:0];
  assign mem_wdata = r_q[src];

  risc_spm_ram #(
    .WORD_SIZE(WORD_SIZE),
    .MEM_SIZE (MEM_SIZE)
  ) Ram (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (ar_q),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  // Y holds src latched in DEC, so src == dest still sees the pre-write operand.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OpAdd:   alu_res = r_q[dest] + y_q;
      OpSub:   alu_res = r_q[dest] - y_q;
      OpAnd:   alu_res = r_q[dest] & y_q;
      OpNot:   alu_res = ~r_q[src];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;
    y_d     = y_q;
    z_d     = z_q;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFet1;
      StFet1: begin
        ar_d    = pc_q;
        state_d = StFet2;
      end
      StFet2: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + One;
        state_d = StDec;
      end
      StDec: begin
        state_d = StFet1;
        case (opcode)
          OpNop: ;
          OpAdd, OpSub, OpAnd: begin
            y_d     = r_q[src];
            state_d = StEx1;
          end
          OpNot: begin
            r_d[dest] = alu_res;
            z_d       = (alu_res == '0);
          end
          OpRd: begin
            ar_d    = pc_q;
            state_d = StRd1;
          end
          OpWr: begin
            ar_d    = pc_q;
            state_d = StWr1;
          end
          OpBr: begin
            ar_d    = pc_q;
            state_d = StBr1;
          end
          OpBrz: begin
            if (z_q) begin
              ar_d    = pc_q;
              state_d = StBr1;
            end else begin
              pc_d = pc_q + One;
            end
          end
          OpHalt: state_d = StHalt;
          default: begin
`ifdef RISC_SPM_ILLEGAL_HALT_EN
            state_d = StHalt;
`else
            state_d = StFet1;
`endif
          end
        endcase
      end
      StEx1: begin
        r_d[dest] = alu_res;
        z_d       = (alu_res == '0);
        state_d   = StFet1;
      end
      StRd1: begin
        ar_d    = mem_rdata;
        pc_d    = pc_q + One;
        state_d = StRd2;
      end
      StRd2: begin
        r_d[dest] = mem_rdata;
        state_d   = StFet1;
      end
      StWr1: begin
        ar_d    = mem_rdata;
        pc_d    = pc_q + One;
        state_d = StWr2;
      end
      StWr2: begin
        mem_we  = ~rst;
        state_d = StFet1;
      end
      StBr1: begin
        ar_d    = mem_rdata;
        state_d = StBr2;
      end
      StBr2: begin
        pc_d    = mem_rdata;
        state_d = StFet1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '{default: '0};
      pc_q    <= '0;
      ir_q    <= '0;
      ar_q    <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_risc_spm.sv
// Directed self-checking bench for risc_spm: programs loaded by backdoor into dut.Ram.memory.
module tb_risc_spm;
  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StFet1 = 4'd1;
  localparam logic [3:0] StDec  = 4'd3;
  localparam logic [3:0] StEx1  = 4'd4;
  localparam logic [3:0] StRd2  = 4'd6;
  localparam logic [3:0] StWr2  = 4'd8;
  localparam logic [3:0] StHalt = 4'd11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_mem [256];

  risc_spm dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    dut.Ram.memory[a] = d;
    exp_mem[a] = d;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) poke(i, 8'h00);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mem_check(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (dut.Ram.memory[i] !== exp_mem[i]) diffs++;
    check(tag, (diffs > 255) ? 8'hFF : 8'(diffs), 8'h00);
  endtask

  task automatic wait_halt(input string tag, input int max_edges);
    int k = 0;
    while (dut.state_q != StHalt && k < max_edges) begin
      edges(1);
      k++;
    end
    check(tag, {4'd0, dut.state_q}, StHalt);
  endtask

  initial begin
    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_r0", dut.r_q[0], 8'h00);
    check("rst_r1", dut.r_q[1], 8'h00);
    check("rst_r2", dut.r_q[2], 8'h00);
    check("rst_r3", dut.r_q[3], 8'h00);
    check("rst_pc", dut.pc_q, 8'h00);
    check("rst_ir", dut.ir_q, 8'h00);
    check("rst_ar", dut.ar_q, 8'h00);
    check("rst_y", dut.y_q, 8'h00);
    check("rst_z", {7'd0, dut.z_q}, 8'h00);
    check("rst_state", {4'd0, dut.state_q}, {4'd0, StIdle});

    // All-NOP memory: PC steps every 3 cycles
    enter_reset();
    release_reset();
    edges(4);
    check("nop_pc4", dut.pc_q, 8'h01);
    edges(26);
    check("nop_pc30", dut.pc_q, 8'h0A);
    check("nop_state30", {4'd0, dut.state_q}, {4'd0, StDec});
    check("nop_r0", dut.r_q[0], 8'h00);
    check("nop_r3", dut.r_q[3], 8'h00);

    // Counted loop
    enter_reset();
    poke(0, 8'h00);
    poke(1, 8'h52); poke(2, 8'd130);
    poke(3, 8'h53); poke(4, 8'd131);
    poke(5, 8'h51); poke(6, 8'd128);
    poke(7, 8'h50); poke(8, 8'd129);
    poke(9, 8'h21);
    poke(10, 8'h80); poke(11, 8'd134);
    poke(12, 8'h1B);
    poke(13, 8'h70); poke(14, 8'd140);
    poke(128, 8'd6); poke(129, 8'd1); poke(130, 8'd2); poke(131, 8'd0);
    poke(134, 8'd139); poke(139, 8'hF0); poke(140, 8'd9);
    release_reset();
    wait_halt("loop_halt", 120);
    check("loop_r0", dut.r_q[0], 8'd1);
    check("loop_r1", dut.r_q[1], 8'd0);
    check("loop_r2", dut.r_q[2], 8'd2);
    check("loop_r3", dut.r_q[3], 8'd10);
    check("loop_z", {7'd0, dut.z_q}, 8'h01);
    check("loop_pc", dut.pc_q, 8'd140);
    mem_check("loop_mem");
    edges(5);
    check("halt_stays", {4'd0, dut.state_q}, StHalt);
    check("halt_pc", dut.pc_q, 8'd140);

    // WR then RD through memory
    enter_reset();
    poke(0, 8'h50); poke(1, 8'd100);
    poke(2, 8'h60); poke(3, 8'd200);
    poke(4, 8'h53); poke(5, 8'd200);
    poke(6, 8'hF0);
    poke(100, 8'h5A);
    release_reset();
    wait_halt("wrrd_halt", 40);
    check("wrrd_mem200", dut.Ram.memory[200], 8'h5A);
    check("wrrd_r3", dut.r_q[3], 8'h5A);
    exp_mem[200] = 8'h5A;
    mem_check("wrrd_mem");

    // Arithmetic and Z flag, checked at exact cycle boundaries
    enter_reset();
    poke(0, 8'h50); poke(1, 8'd100);
    poke(2, 8'h51); poke(3, 8'd101);
    poke(4, 8'h14);
    poke(5, 8'h52); poke(6, 8'd102);
    poke(7, 8'h4B);
    poke(8, 8'h3E);
    poke(9, 8'h53); poke(10, 8'd104);
    poke(11, 8'hF0);
    poke(100, 8'hFF); poke(101, 8'h01); poke(102, 8'h0F); poke(104, 8'h77);
    release_reset();
    edges(14);
    check("add_pending_r0", dut.r_q[0], 8'hFF);
    check("add_pending_state", {4'd0, dut.state_q}, {4'd0, StEx1});
    edges(1);
    check("add_r0", dut.r_q[0], 8'h00);
    check("add_z", {7'd0, dut.z_q}, 8'h01);
    edges(5);
    check("rd_r2", dut.r_q[2], 8'h0F);
    check("rd_keeps_z", {7'd0, dut.z_q}, 8'h01);
    edges(3);
    check("not_r3", dut.r_q[3], 8'hF0);
    check("not_z", {7'd0, dut.z_q}, 8'h00);
    edges(4);
    check("and_r2", dut.r_q[2], 8'h00);
    check("and_z", {7'd0, dut.z_q}, 8'h01);
    edges(5);
    check("rd2_r3", dut.r_q[3], 8'h77);
    check("rd2_keeps_z", {7'd0, dut.z_q}, 8'h01);
    edges(3);
    check("arith_halt", {4'd0, dut.state_q}, StHalt);
    check("arith_pc", dut.pc_q, 8'd12);

    // BRZ untaken then taken, SUB Rn,Rn
    enter_reset();
    poke(0, 8'h51); poke(1, 8'd101);
    poke(2, 8'h15);
    poke(3, 8'h80); poke(4, 8'd100);
    poke(5, 8'h25);
    poke(6, 8'h80); poke(7, 8'd102);
    poke(8, 8'hF0);
    poke(20, 8'hF0);
    poke(100, 8'd30); poke(101, 8'd5); poke(102, 8'd20);
    release_reset();
    edges(10);
    check("addself_r1", dut.r_q[1], 8'h0A);
    check("addself_z", {7'd0, dut.z_q}, 8'h00);
    edges(2);
    check("brz_dec_pc", dut.pc_q, 8'd4);
    check("brz_dec_state", {4'd0, dut.state_q}, {4'd0, StDec});
    edges(1);
    check("brz_nt_pc", dut.pc_q, 8'd5);
    check("brz_nt_state", {4'd0, dut.state_q}, {4'd0, StFet1});
    edges(4);
    check("subself_r1", dut.r_q[1], 8'h00);
    check("subself_z", {7'd0, dut.z_q}, 8'h01);
    edges(5);
    check("brz_t_pc", dut.pc_q, 8'd20);
    check("brz_t_state", {4'd0, dut.state_q}, {4'd0, StFet1});
    edges(3);
    check("brz_halt", {4'd0, dut.state_q}, StHalt);
    check("brz_halt_pc", dut.pc_q, 8'd21);

    // Reset asserted during RD2
    enter_reset();
    poke(0, 8'h50); poke(1, 8'd100);
    poke(2, 8'h51); poke(3, 8'd101);
    poke(4, 8'hF0);
    poke(100, 8'h33); poke(101, 8'h44);
    release_reset();
    edges(10);
    check("abort_pre_state", {4'd0, dut.state_q}, {4'd0, StRd2});
    check("abort_pre_r0", dut.r_q[0], 8'h33);
    #1 rst = 1'b1;
    #1;
    check("abort_r0", dut.r_q[0], 8'h00);
    check("abort_pc", dut.pc_q, 8'h00);
    check("abort_ir", dut.ir_q, 8'h00);
    check("abort_ar", dut.ar_q, 8'h00);
    check("abort_state", {4'd0, dut.state_q}, {4'd0, StIdle});
    edges(1);
    check("abort_r1", dut.r_q[1], 8'h00);
    check("abort_hold_state", {4'd0, dut.state_q}, {4'd0, StIdle});
    mem_check("abort_mem");
    release_reset();
    edges(3);
    check("restart_ir", dut.ir_q, 8'h50);
    check("restart_pc", dut.pc_q, 8'h01);
    edges(3);
    check("restart_r0", dut.r_q[0], 8'h33);

    // Reset asserted during WR2 must suppress the write
    enter_reset();
    poke(0, 8'h60); poke(1, 8'd150);
    poke(2, 8'hF0);
    poke(150, 8'hAA);
    release_reset();
    edges(5);
    check("wrabort_pre_state", {4'd0, dut.state_q}, {4'd0, StWr2});
    #1 rst = 1'b1;
    edges(1);
    check("wrabort_mem150", dut.Ram.memory[150], 8'hAA);
    mem_check("wrabort_mem");
    release_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
